// File: rtl/snoop_pkg.sv
// Shared types for the MSI snooping cache controller.
// Holds the line coherence states, the snoop-bus command codes and the
// controller FSM encoding.
package snoop_pkg;

  typedef enum logic [1:0] {
    ST_I = 2'b00,
    ST_S = 2'b01,
    ST_M = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE   = 2'd0,
    CMD_RDMISS = 2'd1,
    CMD_WRMISS = 2'd2,
    CMD_WB     = 2'd3
  } bus_cmd_t;

  typedef enum logic [2:0] {
    F_IDLE,
    F_RESP,
    F_WB_ARB,
    F_MISS_ARB,
    F_FILL
  } fsm_t;

endpackage

// File: rtl/snoop_cache_ctrl_if.sv
// Signal bundle around one snooping cache controller.
// Groups the CPU request/response, arbiter/bus master side, fill return,
// snoop input and flush output.
//   slave  : the cache controller's view
//   master : the environment's view (CPU, arbiter, bus, other caches)
interface snoop_cache_ctrl_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ID_W   = 2
);
  logic              cpu_valid;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;
  logic              bus_req;
  logic              bus_gnt;
  logic [1:0]        bus_cmd;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              fill_valid;
  logic [DATA_W-1:0] fill_data;
  logic              snp_valid;
  logic [1:0]        snp_cmd;
  logic [ADDR_W-1:0] snp_addr;
  logic [ID_W-1:0]   snp_src;
  logic              flush_valid;
  logic [ADDR_W-1:0] flush_addr;
  logic [DATA_W-1:0] flush_data;

  modport slave (
    input  cpu_valid, cpu_we, cpu_addr, cpu_wdata, bus_gnt, fill_valid, fill_data,
           snp_valid, snp_cmd, snp_addr, snp_src,
    output cpu_ready, cpu_rdata, bus_req, bus_cmd, bus_addr, bus_wdata,
           flush_valid, flush_addr, flush_data
  );

  modport master (
    output cpu_valid, cpu_we, cpu_addr, cpu_wdata, bus_gnt, fill_valid, fill_data,
           snp_valid, snp_cmd, snp_addr, snp_src,
    input  cpu_ready, cpu_rdata, bus_req, bus_cmd, bus_addr, bus_wdata,
           flush_valid, flush_addr, flush_data
  );
endinterface

// File: rtl/snoop_line_array.sv
// Direct-mapped line store: LINES x {state, tag, data}.
// Ports: clk/reset; CPU port (cpu_idx read, cpu_we write of state/tag/data);
// snoop port (snp_en/snp_cmd/snp_idx/snp_tag) that downgrades hit lines and
// produces a registered flush pulse (flush_valid/addr/data) for Modified hits.
// Only state bits are reset. cpu_state is the post-snoop state so the
// controller decides on what the line will be after this cycle's snoop.
module snoop_line_array
  import snoop_pkg::*;
#(
  parameter int unsigned LINES   = 4,
  parameter int unsigned TAG_W   = 3,
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned INDEX_W = $clog2(LINES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [INDEX_W-1:0]       cpu_idx,
  output state_t                   cpu_state,
  output logic [TAG_W-1:0]         cpu_tag_rd,
  output logic [DATA_W-1:0]        cpu_data_rd,
  input  logic                     cpu_we,
  input  state_t                   cpu_wstate,
  input  logic [TAG_W-1:0]         cpu_wtag,
  input  logic [DATA_W-1:0]        cpu_wdata,
  input  logic                     snp_en,
  input  logic [1:0]               snp_cmd,
  input  logic [INDEX_W-1:0]       snp_idx,
  input  logic [TAG_W-1:0]         snp_tag,
  output logic                     flush_valid,
  output logic [TAG_W+INDEX_W-1:0] flush_addr,
  output logic [DATA_W-1:0]        flush_data
);
  state_t            st_q   [LINES];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  logic   snp_we;
  logic   snp_flush;
  state_t snp_state;

  always_comb begin
    snp_we    = 1'b0;
    snp_flush = 1'b0;
    snp_state = ST_I;
    if (snp_en && st_q[snp_idx] != ST_I && tag_q[snp_idx] == snp_tag) begin
      case (bus_cmd_t'(snp_cmd))
        CMD_RDMISS: if (st_q[snp_idx] == ST_M) begin
          snp_we    = 1'b1;
          snp_flush = 1'b1;
          snp_state = ST_S;
        end
        CMD_WRMISS: begin
          snp_we    = 1'b1;
          snp_flush = (st_q[snp_idx] == ST_M);
          snp_state = ST_I;
        end
        default: ;
      endcase
    end
  end

  assign cpu_state   = (snp_we && snp_idx == cpu_idx) ? snp_state : st_q[cpu_idx];
  assign cpu_tag_rd  = tag_q[cpu_idx];
  assign cpu_data_rd = data_q[cpu_idx];

  // Snoop write comes last so it wins on a shared index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < LINES; i++) st_q[i] <= ST_I;
    end else begin
      if (cpu_we) st_q[cpu_idx] <= cpu_wstate;
      if (snp_we) st_q[snp_idx] <= snp_state;
    end
  end

  always_ff @(posedge clk) begin
    if (cpu_we) begin
      tag_q[cpu_idx]  <= cpu_wtag;
      data_q[cpu_idx] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_valid <= 1'b0;
      flush_addr  <= '0;
      flush_data  <= '0;
    end else begin
      flush_valid <= snp_flush;
      flush_addr  <= snp_flush ? {snp_tag, snp_idx} : '0;
      flush_data  <= snp_flush ? data_q[snp_idx] : '0;
    end
  end
endmodule

// File: rtl/snoop_cache_ctrl.sv
// MSI snooping cache controller, one per processor on the shared snoop bus.
// Ports: clk, reset (async, active-high), bus (slave modport): CPU request/
// response, arbiter request/grant with bus command/address/write-back data,
// fill return, snoop input and flush output.
// Serves loads/stores from a direct-mapped line array, writes back Modified
// victims, issues RDMISS/WRMISS (WRMISS without fill for an S->M upgrade).
module snoop_cache_ctrl
  import snoop_pkg::*;
#(
  parameter int unsigned PROC_ID = 0,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned LINES   = 4,
  parameter int unsigned TAG_W   = 3,
  parameter int unsigned DATA_W  = 4
) (
  input logic               clk,
  input logic               reset,
  snoop_cache_ctrl_if.slave bus
);
  localparam int unsigned INDEX_W = $clog2(LINES);
  localparam int unsigned ADDR_W  = TAG_W + INDEX_W;

  logic [INDEX_W-1:0] cpu_idx;
  logic [TAG_W-1:0]   cpu_tag;
  logic               snp_en;
  assign cpu_idx = bus.cpu_addr[INDEX_W-1:0];
  assign cpu_tag = bus.cpu_addr[ADDR_W-1:INDEX_W];
  assign snp_en  = bus.snp_valid && (bus.snp_src != ID_W'(PROC_ID));

  state_t             line_state;
  logic [TAG_W-1:0]   line_tag;
  logic [DATA_W-1:0]  line_data;
  logic               arr_we;
  state_t             arr_wstate;
  logic [TAG_W-1:0]   arr_wtag;
  logic [DATA_W-1:0]  arr_wdata;

  snoop_line_array #(.LINES(LINES), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_lines (
    .clk         (clk),
    .reset       (reset),
    .cpu_idx     (cpu_idx),
    .cpu_state   (line_state),
    .cpu_tag_rd  (line_tag),
    .cpu_data_rd (line_data),
    .cpu_we      (arr_we),
    .cpu_wstate  (arr_wstate),
    .cpu_wtag    (arr_wtag),
    .cpu_wdata   (arr_wdata),
    .snp_en      (snp_en),
    .snp_cmd     (bus.snp_cmd),
    .snp_idx     (bus.snp_addr[INDEX_W-1:0]),
    .snp_tag     (bus.snp_addr[ADDR_W-1:INDEX_W]),
    .flush_valid (bus.flush_valid),
    .flush_addr  (bus.flush_addr),
    .flush_data  (bus.flush_data)
  );

  fsm_t              st_q, st_d;
  logic              gap_q, gap_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              bus_req_c;
  logic [1:0]        bus_cmd_c;
  logic [ADDR_W-1:0] bus_addr_c;
  logic [DATA_W-1:0] bus_wdata_c;
  logic              tag_hit;

  assign tag_hit = (line_tag == cpu_tag) && (line_state != ST_I);

  always_comb begin
    st_d        = st_q;
    gap_d       = 1'b0;
    rdata_d     = rdata_q;
    arr_we      = 1'b0;
    arr_wstate  = ST_I;
    arr_wtag    = line_tag;
    arr_wdata   = line_data;
    bus_req_c   = 1'b0;
    bus_cmd_c   = CMD_NONE;
    bus_addr_c  = '0;
    bus_wdata_c = '0;
    case (st_q)
      F_IDLE: if (bus.cpu_valid) begin
        if (tag_hit && (!bus.cpu_we || line_state == ST_M)) begin
          st_d = F_RESP;
          if (bus.cpu_we) begin
            arr_we     = 1'b1;
            arr_wstate = ST_M;
            arr_wtag   = cpu_tag;
            arr_wdata  = bus.cpu_wdata;
          end else begin
            rdata_d = line_data;
          end
        end else if (!tag_hit && line_state == ST_M) begin
          st_d = F_WB_ARB;
        end else begin
          st_d = F_MISS_ARB;
        end
      end
      F_RESP: st_d = F_IDLE;
      // A victim downgraded by a snoop while waiting no longer needs its
      // write-back, so WB_ARB then falls through to the miss request. gap_q
      // drops bus_req for one cycle between the WB and the following miss.
      F_WB_ARB, F_MISS_ARB: begin
        bus_req_c = !gap_q;
        if (st_q == F_WB_ARB && line_state == ST_M) begin
          if (bus.bus_gnt) begin
            bus_cmd_c   = CMD_WB;
            bus_addr_c  = {line_tag, cpu_idx};
            bus_wdata_c = line_data;
            arr_we      = 1'b1;
            arr_wstate  = ST_I;
            st_d        = F_MISS_ARB;
            gap_d       = 1'b1;
          end
        end else if (bus_req_c && bus.bus_gnt) begin
          bus_addr_c = bus.cpu_addr;
          bus_cmd_c  = bus.cpu_we ? CMD_WRMISS : CMD_RDMISS;
          arr_we     = 1'b1;
          if (bus.cpu_we && tag_hit && line_state == ST_S) begin
            arr_wstate = ST_M;
            arr_wtag   = cpu_tag;
            arr_wdata  = bus.cpu_wdata;
            st_d       = F_RESP;
          end else begin
            // Invalidate the old line now so nothing can snoop it during FILL.
            arr_wstate = ST_I;
            st_d       = F_FILL;
          end
        end else begin
          st_d = F_MISS_ARB;
        end
      end
      F_FILL: if (bus.fill_valid) begin
        arr_we   = 1'b1;
        arr_wtag = cpu_tag;
        st_d     = F_RESP;
        if (bus.cpu_we) begin
          arr_wstate = ST_M;
          arr_wdata  = bus.cpu_wdata;
        end else begin
          arr_wstate = ST_S;
          arr_wdata  = bus.fill_data;
          rdata_d    = bus.fill_data;
        end
      end
      default: st_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= F_IDLE;
      gap_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      st_q    <= st_d;
      gap_q   <= gap_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.cpu_ready = (st_q == F_RESP);
  assign bus.cpu_rdata = rdata_q;
  assign bus.bus_req   = bus_req_c;
  assign bus.bus_cmd   = bus_cmd_c;
  assign bus.bus_addr  = bus_addr_c;
  assign bus.bus_wdata = bus_wdata_c;
endmodule
